// File: rtl/button_if.sv
// Button conditioner signal bundle: raw active-low pin in, clean level and strobes out.
interface button_if;
    logic btn_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    modport master (
        output btn_n,
        input  pressed, press_pulse, release_pulse, long_press
    );

    modport slave (
        input  btn_n,
        output pressed, press_pulse, release_pulse, long_press
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces an active-low push-button. Emits a held level plus
// single-cycle press, release and long-press strobes.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int CNT_W             = 24
) (
    input  logic     clk,
    input  logic     rst,
    button_if.slave  bus
);
    typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_t;

    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_SAT  = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] dcnt, dcnt_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [1:0]       sync_pipe;
    logic             sync_n;
    logic             held, held_nxt, long_nxt;
    logic             pressed_q, press_q, release_q, long_q;

    assign sync_n = sync_pipe[1];

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= 2'b11;
        else     sync_pipe <= {sync_pipe[0], bus.btn_n};
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        hcnt_nxt  = hcnt;
        case (state)
            REL: if (!sync_n) begin
                state_nxt = CHK_P;
                dcnt_nxt  = '0;
            end
            CHK_P: begin
                if (sync_n)              state_nxt = REL;
                else if (dcnt == D_LAST) state_nxt = PRS;
                else                     dcnt_nxt  = dcnt + CNT_W'(1);
            end
            PRS: if (sync_n) begin
                state_nxt = CHK_R;
                dcnt_nxt  = '0;
            end
            CHK_R: begin
                if (!sync_n)             state_nxt = PRS;
                else if (dcnt == D_LAST) state_nxt = REL;
                else                     dcnt_nxt  = dcnt + CNT_W'(1);
            end
            default: state_nxt = REL;
        endcase

        held     = (state == PRS) || (state == CHK_R);
        held_nxt = (state_nxt == PRS) || (state_nxt == CHK_R);

        if (held && hcnt != L_SAT)                 hcnt_nxt = hcnt + CNT_W'(1);
        if (state == CHK_P && state_nxt == PRS)    hcnt_nxt = '0;
        if (state_nxt == REL)                      hcnt_nxt = '0;

        // An accepted release on the same edge suppresses the long-press strobe.
        long_nxt = held && held_nxt && (hcnt == L_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REL;
            dcnt      <= '0;
            hcnt      <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            hcnt      <= hcnt_nxt;
            pressed_q <= held_nxt;
            press_q   <= held_nxt & ~pressed_q;
            release_q <= ~held_nxt & pressed_q;
            long_q    <= long_nxt;
        end
    end

    assign bus.pressed       = pressed_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioning stage for an active-low mechanical push-button on the icestick board (12 MHz clock). It synchronises the raw pin, debounces it with a glitch-rejecting state machine and emits a clean held level plus single-cycle press, release and long-press pulses. Counters, mode selectors and LED logic downstream consume these pulses directly and need no timing logic of their own.

## Interface
- DEBOUNCE_CYCLES, default 120000: cycles the synchronised input must stay at the new level before the change is accepted (10 ms at 12 MHz). Legal range is ≥1.
- LONG_PRESS_CYCLES, default 12000000: cycles after press_pulse at which long_press fires (1 s). Legal range is ≥1.
- CNT_W, default 24: width of the debounce and hold counters. Both parameters must be < 2^CNT_W.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_n  in  1  raw button pin, active-low, asynchronous to clk.
- pressed  out  1  debounced level: 1 while the button is logically held.
- press_pulse  out  1  one-cycle strobe when a press is accepted.
- release_pulse  out  1  one-cycle strobe when a release is accepted.
- long_press  out  1  one-cycle strobe when the hold reaches LONG_PRESS_CYCLES.

## Operation
- **Synchroniser.** btn_n passes through two flops, both resetting to 1 (released). sync_n is the second flop. No other logic samples btn_n.
- **State machine.** States are REL (stable released), CHK_P (checking a press), PRS (stable pressed) and CHK_R (checking a release).
  - REL: if sync_n=0, go to CHK_P and set dcnt=0.
  - CHK_P: if sync_n=1, return to REL (glitch, no output). Otherwise, if dcnt=DEBOUNCE_CYCLES-1, go to PRS. Otherwise dcnt+1.
  - PRS: if sync_n=1, go to CHK_R and set dcnt=0.
  - CHK_R: if sync_n=0, return to PRS (glitch, no output, pressed stays 1). Otherwise, if dcnt=DEBOUNCE_CYCLES-1, go to REL. Otherwise dcnt+1.
  - Unknown or illegal encoding goes to REL.
- **Outputs.** All outputs are registered.
  - pressed=1 in PRS and CHK_R.
  - press_pulse is high for exactly the first cycle in which pressed=1.
  - release_pulse is high for exactly the first cycle in which pressed=0 after a held period.
- **Hold counter (hcnt).**
  - Cleared on the CHK_P→PRS transition.
  - Increments every cycle while in PRS or CHK_R.
  - Saturates at LONG_PRESS_CYCLES; it never wraps and long_press never repeats within one hold.
  - long_press is registered high on the edge where hcnt=LONG_PRESS_CYCLES-1 increments.
  - hcnt is cleared when entering REL.
- **Simultaneous events.** If a release is accepted on the same edge long_press would fire, release wins: release_pulse=1 and long_press stays 0.
- **Arithmetic.** dcnt and hcnt are unsigned CNT_W bits. Comparisons are exact equality. No overflow is possible within the legal parameter range.

## Timing
- **Reset.** The block enters REL immediately, regardless of clk.
  - Sync flops are set to 1; dcnt and hcnt are set to 0.
  - pressed, press_pulse, release_pulse and long_press are all 0.
- **Press latency.** The first clk edge sampling btn_n=0 is edge 0. sync_n=0 at edge 1, CHK_P is entered at edge 2, and PRS is entered at edge DEBOUNCE_CYCLES+2. pressed and press_pulse are high after that edge.
- **Acceptance rule.** btn_n must be sampled low on DEBOUNCE_CYCLES+1 consecutive edges. A low run of DEBOUNCE_CYCLES samples or fewer produces no output.
- **Release.** Same latency and acceptance rule as a press, with polarity inverted.
- **Long press.** long_press fires exactly LONG_PRESS_CYCLES cycles after the press_pulse cycle.
- **Pulse spacing.** Strobes are always 1 cycle wide. press_pulse and release_pulse can never occur within DEBOUNCE_CYCLES+1 cycles of each other.
- **Reset mid-operation.** Any state aborts to REL with no pulse emitted.
- **Held through reset.** If the button is held while rst deasserts, a normal press_pulse follows at edge DEBOUNCE_CYCLES+2 after reset release.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=10.
- **Clean press.** btn_n 1→0, held low → pressed and press_pulse go high after edge 6 (edge 0 is the first low sample); press_pulse is low again after edge 7.
- **Glitch rejection.** btn_n low for 4 cycles, then high → pressed, press_pulse and release_pulse all stay 0 throughout.
- **Release bounce.** While held, toggle btn_n high 3 cycles, low 2, then high steady → no extra press_pulse; exactly one release_pulse, 6 edges after the final rise; pressed=0 afterwards.
- **Long press.** Hold low → long_press pulses once, 10 cycles after press_pulse. Keep holding 50 more cycles → no second long_press.
- **Release/long-press collision.** Time the release so acceptance lands on the long_press edge → release_pulse=1 and long_press=0 on that cycle.
- **Reset.** Assert rst asynchronously in CHK_R with pressed=1 → all outputs 0 immediately, with no clock edge needed. Deassert rst with btn_n held low → press_pulse after edge 6.
